ntt_ctrl: RTL
=============

# ntt_ctrl

Sequencer and address generator for the 256-point forward NTT over q = 8380417. Sits directly upstream of the `NTT` butterfly unit. Walks the 8 Cooley–Tukey layers, issuing one butterfly per cycle:
- coefficient-RAM read addresses (`j`, `j+len`), which feed `in0` and `in1`;
- the zeta ROM index, which feeds `phi`;
- matching write-back addresses, delayed to line up with the butterfly's `out0` and `out1`.

The block moves no data: it is pure control, with a delay line for write addresses and a layer-drain interlock.

## Interface
Parameters:
- `BF_LATENCY`, default 4: cycles from `rd_en` to the matching butterfly result at `out0`/`out1`. Includes the 1-cycle RAM read. Legal range 1..15.

Ports:
- `clk`  in  1  clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  single-cycle request to begin a transform; honoured only in IDLE
- `busy`  out  1  high while a transform is in progress
- `done`  out  1  one-cycle pulse when the last write-back has been issued
- `rd_en`  out  1  butterfly issue strobe / RAM read enable
- `rd_addr0`  out  8  read address `j` (to `in0`)
- `rd_addr1`  out  8  read address `j+len` (to `in1`)
- `zeta_idx`  out  8  zeta ROM index k (to `phi`), valid with `rd_en`
- `wr_en`  out  1  write-back enable, aligned to butterfly outputs
- `wr_addr0`  out  8  write address for `out0`
- `wr_addr1`  out  8  write address for `out1`
- `layer`  out  3  current layer index 0..7 (debug/status)

## Operation
FSM states: IDLE, RUN, DRAIN, DONE.
- **IDLE**: `start`=1 goes to RUN, with L=0 and butterfly counter b=0.
- **RUN**: `rd_en`=1 every cycle and b increments. When b=127, go to DRAIN and clear the drain counter.
- **DRAIN**: `rd_en`=0 for exactly `BF_LATENCY` cycles. This guarantees that every write of layer L has been issued before layer L+1 reads.
  - After the drain, if L<7: L increments, b resets to 0, and the FSM goes to RUN.
  - Otherwise, the FSM goes to DONE.
- **DONE**: `done`=1 for one cycle, then IDLE.

Address arithmetic for layer L and counter b (all unsigned, 8-bit, no wrap possible):
- len = 128 >> L
- g = b >> (7−L)
- o = b & (len−1)
- `rd_addr0` = g·2·len + o
- `rd_addr1` = `rd_addr0` + len
- `zeta_idx` = (1 << L) + g, which covers 1..255 in order, matching the reference zeta table.

Write-back path:
- A shift register of depth `BF_LATENCY` carries {valid, addr0, addr1}.
- `wr_en`/`wr_addr*` at cycle c+`BF_LATENCY` equal `rd_en`/`rd_addr*` at cycle c.

Boundary and hazard rules:
- `start` while `busy`=1 or in DONE: ignored; no restart, no effect on the counters.
- Reset in any state: FSM to IDLE, L=0, b=0, and the delay line cleared. No `wr_en` may appear after reset, even if reads were in flight.
- `start` held high continuously: one transform; a new one begins only after DONE returns to IDLE.
- `rd_en` is never high in DRAIN, DONE or IDLE.
- `wr_en` may be high in DRAIN, never in IDLE.

Output values:
- Reset value of every output: 0.
- When `rd_en`=0, `rd_addr*`/`zeta_idx` hold 0.
- When `wr_en`=0, `wr_addr*` hold 0.

## Timing
Let D = `BF_LATENCY`, and let `start` be sampled high at cycle 0.
- First `rd_en` at cycle 1, with L=0, b=0.
- Layer L reads occupy cycles 1+L·(128+D) through 128+L·(128+D).
- DRAIN occupies the D cycles after each layer.
- `busy`=1 from cycle 1 through cycle 8·(128+D) inclusive.
- `done` pulses at cycle 8·(128+D)+1. For D=4 this is cycle 1057.
- The last `wr_en` is at cycle 8·(128+D), with `wr_addr0`=254 and `wr_addr1`=255.
- Throughput: one butterfly per cycle inside a layer; 1024 butterflies per transform.

## Test plan
- Reset, then `start` at cycle 0 with D=4:
  - cycle 1: `rd_addr0`=0, `rd_addr1`=128, `zeta_idx`=1;
  - cycle 5: `wr_en`=1, `wr_addr0`=0, `wr_addr1`=128;
  - cycle 128: `rd_addr0`=127, `rd_addr1`=255;
  - cycles 129–132: `rd_en`=0;
  - cycle 133: L=1, `rd_addr0`=0, `rd_addr1`=64, `zeta_idx`=2.
- Full transform with a scoreboard against the software loop:
  - all 1024 (`rd_addr0`, `rd_addr1`, `zeta_idx`) triples match in order;
  - `done` fires only at cycle 1057;
  - the last read triple is (254, 255, 255).
- Hazard check: for every layer, the last `wr_en` of layer L precedes the first `rd_en` of layer L+1 by at least 1 cycle. Check with D=1 and D=15.
- Pulse `start` at cycle 300 during RUN → sequence unchanged; `done` still fires at cycle 1057.
- Assert `reset` at cycle 200, during layer 1 → next cycle:
  - all outputs are 0 and the FSM is in IDLE;
  - no `wr_en` appears during the following 20 cycles;
  - a new `start` reproduces the cycle-1 values.
- Hold `start`=1 continuously → two back-to-back transforms. The second first `rd_en` comes 2 cycles after `done` (one cycle to return to IDLE, then RUN).

Source files
------------

// File: rtl/ntt_ctrl.sv
// Sequencer/address generator for the 256-point forward NTT (8 Cooley-Tukey layers, q = 8380417).
// Latency: first read 1 cycle after start; write-back addresses trail reads by BF_LATENCY cycles.
// Backpressure: none; issues one butterfly per cycle and drains BF_LATENCY cycles between layers.
module ntt_ctrl #(
  parameter int BF_LATENCY = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       rd_en,
  output logic [7:0] rd_addr0,
  output logic [7:0] rd_addr1,
  output logic [7:0] zeta_idx,
  output logic       wr_en,
  output logic [7:0] wr_addr0,
  output logic [7:0] wr_addr1,
  output logic [2:0] layer
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // One entry of the write-back delay line: issue strobe plus the two addresses.
  typedef struct packed {
    logic       vld;
    logic [7:0] addr0;
    logic [7:0] addr1;
  } wb_t;

  localparam logic [3:0] DRAIN_LAST = 4'(BF_LATENCY - 1);
  localparam int         DL_LAST    = BF_LATENCY - 1;

  state_t     state, state_n;
  logic [6:0] bcnt, bcnt_n;
  logic [2:0] lyr, lyr_n;
  logic [3:0] dcnt, dcnt_n;

  logic [7:0] b8, len, lo, hi, grp, base;
  wb_t [BF_LATENCY-1:0] dline;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bcnt  <= '0;
      lyr   <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_n;
      bcnt  <= bcnt_n;
      lyr   <= lyr_n;
      dcnt  <= dcnt_n;
    end
  end

  // Next-state: walk 128 butterflies per layer, drain the pipeline, advance layer.
  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    lyr_n   = lyr;
    dcnt_n  = dcnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          lyr_n   = '0;
          bcnt_n  = '0;
        end
      end
      RUN: begin
        bcnt_n = bcnt + 7'd1;
        if (bcnt == 7'd127) begin
          state_n = DRAIN;
          dcnt_n  = '0;
        end
      end
      DRAIN: begin
        if (dcnt == DRAIN_LAST) begin
          if (lyr != 3'd7) begin
            lyr_n   = lyr + 3'd1;
            bcnt_n  = '0;
            state_n = RUN;
          end else begin
            state_n = DONE;
          end
        end else begin
          dcnt_n = dcnt + 4'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
        lyr_n   = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  assign rd_en = (state == RUN);
  assign busy  = (state == RUN) || (state == DRAIN);
  assign done  = (state == DONE);
  assign layer = lyr;

  // Butterfly addressing: the group index g sits above the low (7-L) bits of b,
  // so g*2*len is just those upper bits shifted left by one.
  always_comb begin
    b8       = {1'b0, bcnt};
    len      = 8'd128 >> lyr;
    lo       = b8 & (len - 8'd1);
    hi       = b8 & ~(len - 8'd1);
    grp      = b8 >> (3'd7 - lyr);
    base     = (hi << 1) | lo;
    rd_addr0 = '0;
    rd_addr1 = '0;
    zeta_idx = '0;
    if (rd_en) begin
      rd_addr0 = base;
      rd_addr1 = base + len;
      zeta_idx = (8'd1 << lyr) + grp;
    end
  end

  // Write-back delay line; cleared on reset so in-flight reads never write back.
  always_ff @(posedge clk) begin
    if (reset) begin
      dline <= '0;
    end else begin
      dline[0] <= {rd_en, rd_addr0, rd_addr1};
      for (int i = 1; i < BF_LATENCY; i++) begin
        dline[i] <= dline[i-1];
      end
    end
  end

  assign wr_en    = dline[DL_LAST].vld;
  assign wr_addr0 = dline[DL_LAST].addr0;
  assign wr_addr1 = dline[DL_LAST].addr1;

endmodule
